// File: rtl/mul_iter_xunit.sv
// Iterative RV32M multiply pipe: radix-2 shift-add over 32 cycles, result held
// on a val/rdy port toward writeback until granted.
module mul_iter_xunit #(
    parameter int p_seq_num_bits = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      d_val,
    output logic                      d_rdy,
    input  logic [31:0]               d_pc,
    input  logic [p_seq_num_bits-1:0] d_seq_num,
    input  logic [31:0]               d_op1,
    input  logic [31:0]               d_op2,
    input  logic [4:0]                d_waddr,
    input  logic [1:0]                d_uop,
    output logic                      w_val,
    input  logic                      w_rdy,
    output logic [31:0]               w_pc,
    output logic [p_seq_num_bits-1:0] w_seq_num,
    output logic [4:0]                w_waddr,
    output logic [31:0]               w_wdata,
    output logic                      w_wen
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [4:0]                r_cnt;
    logic [63:0]               r_mcand;
    logic [31:0]               r_mplier;
    logic [63:0]               r_acc;
    logic                      r_neg;
    logic [31:0]               r_pc;
    logic [p_seq_num_bits-1:0] r_seq_num;
    logic [4:0]                r_waddr;
    logic [1:0]                r_uop;

    logic        w_accept;
    logic        w_op1_neg;
    logic        w_op2_neg;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [63:0] w_acc_sum;
    logic [63:0] w_acc_final;

    assign w_accept = (r_state == ST_IDLE) && d_val;

    // op1 is signed for MULH/MULHSU, op2 only for MULH; magnitudes feed the unsigned datapath.
    assign w_op1_neg = ((d_uop == 2'd1) || (d_uop == 2'd2)) && d_op1[31];
    assign w_op2_neg = (d_uop == 2'd1) && d_op2[31];
    assign w_abs1    = w_op1_neg ? (32'd0 - d_op1) : d_op1;
    assign w_abs2    = w_op2_neg ? (32'd0 - d_op2) : d_op2;

    assign w_acc_sum   = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
    assign w_acc_final = ((r_cnt == 5'd31) && r_neg) ? (64'd0 - w_acc_sum) : w_acc_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (d_val) w_state_next = ST_CALC;
            ST_CALC: if (r_cnt == 5'd31) w_state_next = ST_DONE;
            ST_DONE: if (w_rdy) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 5'd0;
        end else if (w_accept) begin
            r_cnt <= 5'd0;
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Datapath registers carry no reset; they are always rewritten on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc      <= d_pc;
            r_seq_num <= d_seq_num;
            r_waddr   <= d_waddr;
            r_uop     <= d_uop;
            r_mcand   <= {32'd0, w_abs1};
            r_mplier  <= w_abs2;
            r_neg     <= w_op1_neg ^ w_op2_neg;
            r_acc     <= 64'd0;
        end else if (r_state == ST_CALC) begin
            r_acc    <= w_acc_final;
            r_mcand  <= {r_mcand[62:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
        end
    end

    assign d_rdy     = (r_state == ST_IDLE) && !rst;
    assign w_val     = (r_state == ST_DONE);
    assign w_wen     = w_val;
    assign w_pc      = r_pc;
    assign w_seq_num = r_seq_num;
    assign w_waddr   = r_waddr;
    assign w_wdata   = (r_uop == 2'd0) ? r_acc[31:0] : r_acc[63:32];

endmodule
